// File: rtl/tile_renderer_if.sv
// VRAM read port of the tile renderer: registered address/strobe out,
// synchronous-RAM data back one cycle after the address cycle.
interface tile_renderer_if;
  logic [13:0] vramAddr;
  logic        vramRd;
  logic [7:0]  vramData;

  modport master (output vramAddr, output vramRd, input vramData);
  modport slave  (input vramAddr, input vramRd, output vramData);
endinterface

// File: rtl/tile_renderer.sv
// Pattern-mode tile renderer: fetches name/pattern/color bytes one tile ahead
// of the beam and serialises 8 pixels per tile with a registered output.
module tile_renderer #(
  parameter logic [13:0] NAME_BASE    = 14'h1800,
  parameter logic [13:0] PATTERN_BASE = 14'h0000,
  parameter logic [13:0] COLOR_BASE   = 14'h2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8:0]              xPos,
  input  logic [8:0]              yPos,
  input  logic                    isActive,
  input  logic                    hSync,
  input  logic                    vSync,
  input  logic [3:0]              backdrop,
  tile_renderer_if.master         vram,
  output logic [3:0]              pixel,
  output logic                    hSyncOut,
  output logic                    vSyncOut,
  output logic                    activeOut
);

  typedef enum logic [2:0] {
    IDLE, NAME_REQ, NAME_WAIT, PAT_REQ, PAT_WAIT, COL_REQ, COL_WAIT
  } state_t;

  state_t      state;
  logic [2:0]  fine;
  logic [7:0]  name;
  logic [7:0]  patNext;
  logic [7:0]  colNext;
  logic [7:0]  shifter;
  logic [7:0]  colReg;

  logic        lineOk;
  logic        fetchWin;
  logic [2:0]  phase;
  logic [4:0]  tcolNew;
  logic        curBit;
  logic [7:0]  curCol;

  assign lineOk   = !yPos[8] && (yPos < 9'd192);
  assign fetchWin = lineOk && ($signed(xPos) >= -9'sd8) && ($signed(xPos) <= 9'sd247);
  assign phase    = xPos[2:0];
  assign tcolNew  = xPos[7:3] + 5'd1;

  always_comb begin
    curBit = shifter[7];
    curCol = colReg;
    if (phase == 3'd0) begin
      curBit = patNext[7];
      curCol = colNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fine          <= '0;
      name          <= '0;
      patNext       <= '0;
      colNext       <= '0;
      shifter       <= '0;
      colReg        <= '0;
      vram.vramAddr <= '0;
      vram.vramRd   <= 1'b0;
      pixel         <= '0;
      hSyncOut      <= 1'b0;
      vSyncOut      <= 1'b0;
      activeOut     <= 1'b0;
    end else begin
      hSyncOut    <= hSync;
      vSyncOut    <= vSync;
      activeOut   <= isActive;
      vram.vramRd <= 1'b0;

      // Request addresses are registered on the edge entering each *_REQ state,
      // so the pattern address is built from vramData on the same edge name is latched.
      case (state)
        IDLE: begin
          if (phase == 3'd0 && fetchWin) begin
            state         <= NAME_REQ;
            fine          <= yPos[2:0];
            vram.vramAddr <= NAME_BASE + {4'b0, yPos[7:3], tcolNew};
            vram.vramRd   <= 1'b1;
          end
        end
        NAME_REQ:  state <= NAME_WAIT;
        NAME_WAIT: begin
          state         <= PAT_REQ;
          name          <= vram.vramData;
          vram.vramAddr <= PATTERN_BASE + {3'b0, vram.vramData, fine};
          vram.vramRd   <= 1'b1;
        end
        PAT_REQ:   state <= PAT_WAIT;
        PAT_WAIT: begin
          state         <= COL_REQ;
          patNext       <= vram.vramData;
          vram.vramAddr <= COLOR_BASE + {9'b0, name[7:3]};
          vram.vramRd   <= 1'b1;
        end
        COL_REQ:   state <= COL_WAIT;
        COL_WAIT: begin
          state   <= IDLE;
          colNext <= vram.vramData;
        end
        default:   state <= IDLE;
      endcase

      // Bit 7 of a new tile is taken straight from patNext, so the shifter keeps
      // only the bits still to be shown and presents the next one at bit 7.
      if (phase == 3'd0) begin
        shifter <= {patNext[6:0], 1'b0};
        colReg  <= colNext;
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end

      pixel <= isActive ? (curBit ? curCol[7:4] : curCol[3:0]) : backdrop;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: random VRAM contents, scanline sweeps,
// compared against a per-pixel tile lookup model and an expected read list.
module tb_tile_renderer;
  localparam int NB = 'h1800;
  localparam int PB = 'h0000;
  localparam int CB = 'h2000;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] xPos, yPos;
  logic       isActive, hSync, vSync;
  logic [3:0] backdrop;
  logic [3:0] pixel;
  logic       hSyncOut, vSyncOut, activeOut;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:16383];
  logic [13:0] rdq [$];

  always #5 clk = ~clk;

  tile_renderer_if vif ();

  tile_renderer #(
    .NAME_BASE(14'h1800),
    .PATTERN_BASE(14'h0000),
    .COLOR_BASE(14'h2000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .xPos(xPos),
    .yPos(yPos),
    .isActive(isActive),
    .hSync(hSync),
    .vSync(vSync),
    .backdrop(backdrop),
    .vram(vif.master),
    .pixel(pixel),
    .hSyncOut(hSyncOut),
    .vSyncOut(vSyncOut),
    .activeOut(activeOut)
  );

  // Synchronous VRAM with a log of every strobed address
  always @(posedge clk) begin
    if (vif.vramRd) begin
      vif.vramData <= mem[vif.vramAddr];
      rdq.push_back(vif.vramAddr);
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
  endtask

  function automatic logic [3:0] model_pixel(int x, int y, logic act, logic [3:0] bd);
    int nm, pat, c;
    if (!act) return bd;
    nm  = int'(mem[NB + (y / 8) * 32 + x / 8]);
    pat = int'(mem[(PB + nm * 8 + y % 8) % 16384]);
    c   = int'(mem[(CB + nm / 8) % 16384]);
    if (((pat >> (7 - x % 8)) & 1) == 1) return 4'(c / 16);
    return 4'(c % 16);
  endfunction

  task automatic step(input string tag, input int x, input int y, input logic act,
                      input logic hs, input logic vs, input logic chk, input logic [3:0] ep);
    xPos = x[8:0];
    yPos = y[8:0];
    isActive = act;
    hSync = hs;
    vSync = vs;
    @(posedge clk);
    #1;
    vectors++;
    if (hSyncOut !== hs) begin
      miscompares++;
      $display("FAIL %s hSyncOut x=%0d: got %b expected %b", tag, x, hSyncOut, hs);
    end
    vectors++;
    if (vSyncOut !== vs) begin
      miscompares++;
      $display("FAIL %s vSyncOut x=%0d: got %b expected %b", tag, x, vSyncOut, vs);
    end
    vectors++;
    if (activeOut !== act) begin
      miscompares++;
      $display("FAIL %s activeOut x=%0d: got %b expected %b", tag, x, activeOut, act);
    end
    if (chk) begin
      vectors++;
      if (pixel !== ep) begin
        miscompares++;
        $display("FAIL %s pixel x=%0d y=%0d: got %h expected %h", tag, x, y, pixel, ep);
      end
    end
  endtask

  task automatic run_line(input string tag, input int y, input int x0, input int x1,
                          input logic [3:0] bd, input int skipx);
    logic act;
    backdrop = bd;
    for (int x = x0; x <= x1; x++) begin
      act = (y >= 0 && y < 192 && x >= 0 && x < 256);
      step(tag, x, y, act, 1'($urandom), 1'($urandom), !act || x >= skipx,
           model_pixel(x, y, act, bd));
    end
  endtask

  task automatic check_reads(input string tag, input int y, input int c0);
    int ex[$];
    int nm, n;
    for (int c = c0; c < 32; c++) begin
      n  = NB + (y / 8) * 32 + c;
      nm = int'(mem[n]);
      ex.push_back(n);
      ex.push_back((PB + nm * 8 + y % 8) % 16384);
      ex.push_back((CB + nm / 8) % 16384);
    end
    vectors++;
    if (rdq.size() != ex.size()) begin
      miscompares++;
      $display("FAIL %s read count: got %0d expected %0d", tag, rdq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < rdq.size(); i++) begin
      vectors++;
      if (32'(rdq[i]) !== ex[i]) begin
        miscompares++;
        $display("FAIL %s read[%0d]: got %h expected %h", tag, i, rdq[i], ex[i]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if (pixel !== 4'h0 || vif.vramAddr !== 14'h0 || vif.vramRd !== 1'b0 ||
        hSyncOut !== 1'b0 || vSyncOut !== 1'b0 || activeOut !== 1'b0) begin
      miscompares++;
      $display("FAIL %s outputs: got pix=%h addr=%h rd=%b hs=%b vs=%b act=%b expected all 0",
               tag, pixel, vif.vramAddr, vif.vramRd, hSyncOut, vSyncOut, activeOut);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    xPos = 9'd0; yPos = 9'd0; isActive = 1'b1; hSync = 1'b1; vSync = 1'b1; backdrop = 4'h7;
    @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    check_zero("reset_hold");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_pix [8];
    exp_pix = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};
    fill_mem();
    mem['h1800] = 8'h05;
    mem['h0028] = 8'hA5;
    mem['h2000] = 8'hF1;
    backdrop = 4'h3;
    rdq.delete();
    for (int x = -8; x < 0; x++) step("basic", x, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
    for (int x = 0; x < 8; x++) step("basic", x, 0, 1'b1, 1'b0, 1'b0, 1'b1, exp_pix[x]);
    vectors++;
    if (rdq.size() < 3 || rdq[0] !== 14'h1800 || rdq[1] !== 14'h0028 || rdq[2] !== 14'h2000) begin
      miscompares++;
      $display("FAIL basic reads: got %0d entries first=%h expected 1800,0028,2000",
               rdq.size(), rdq.size() > 0 ? rdq[0] : 14'h0);
    end
    run_line("basic_tail", 0, 8, 256, 4'h3, 0);
  endtask

  task automatic test_row13();
    int nm;
    fill_mem();
    rdq.delete();
    run_line("row13", 13, -16, 256, 4'h4, 0);
    nm = int'(mem['h1820]);
    vectors++;
    if (rdq.size() < 2 || rdq[0] !== 14'h1820 || 32'(rdq[1]) !== (PB + nm * 8 + 5)) begin
      miscompares++;
      $display("FAIL row13 first reads: got %h,%h expected 1820,%h",
               rdq.size() > 0 ? rdq[0] : 14'h0, rdq.size() > 1 ? rdq[1] : 14'h0, PB + nm * 8 + 5);
    end
    check_reads("row13", 13, 0);
  endtask

  task automatic test_random_lines();
    int y;
    for (int k = 0; k < 3; k++) begin
      fill_mem();
      y = int'($urandom_range(0, 191));
      rdq.delete();
      run_line("rand_line", y, -16, 256, 4'($urandom), 0);
      check_reads("rand_line", y, 0);
    end
  endtask

  task automatic test_blank();
    rdq.delete();
    run_line("blank192", 192, -16, 256, 4'hA, 0);
    run_line("blank300", 300, -16, 256, 4'h6, 0);
    vectors++;
    if (rdq.size() != 0) begin
      miscompares++;
      $display("FAIL blank reads: got %0d expected 0", rdq.size());
    end
  endtask

  task automatic test_reset_mid();
    int y;
    fill_mem();
    y = int'($urandom_range(0, 191));
    backdrop = 4'h2;
    for (int x = -16; x <= -6; x++) step("rst_mid_pre", x, y, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
    vectors++;
    if (vif.vramRd !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid pattern strobe: got %b expected 1", vif.vramRd);
    end
    reset = 1'b1;
    #1;
    check_zero("rst_mid_async");
    rdq.delete();
    xPos = 9'h1FB;
    @(posedge clk);
    #1;
    check_zero("rst_mid_hold");
    reset = 1'b0;
    run_line("rst_mid_post", y, -4, 256, 4'h2, 8);
    check_reads("rst_mid_post", y, 1);
  endtask

  task automatic test_sync();
    backdrop = 4'h9;
    for (int i = 0; i < 24; i++)
      step("sync", -16 + i, 200, 1'b0, 1'(i & 1), 1'((i >> 1) & 1), 1'b1, 4'h9);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row13();
    test_random_lines();
    test_blank();
    test_reset_mid();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameter NAME_BASE, default 14'h1800, VRAM base of the 32x24 name table.
REQ-002 SHALL have parameter PATTERN_BASE, default 14'h0000, VRAM base of the 256x8-byte pattern table.
REQ-003 SHALL have parameter COLOR_BASE, default 14'h2000, VRAM base of the 32-byte color table.
REQ-004 Ports SHALL be:
- clk  in  1  pixel clock, single clock domain.
- reset  in  1  asynchronous, active-high.
- xPos  in  9  signed pixel column from the sync generator.
- yPos  in  9  signed pixel line from the sync generator.
- isActive  in  1  pixel lies inside the 256x192 active region.
- hSync  in  1  horizontal sync.
- vSync  in  1  vertical sync.
- backdrop  in  4  border color.
- vramAddr  out  14  VRAM read address.
- vramRd  out  1  read strobe.
- vramData  in  8  read data, valid one cycle after the address cycle (synchronous RAM).
- pixel  out  4  color index.
- hSyncOut  out  1  delayed hSync.
- vSyncOut  out  1  delayed vSync.
- activeOut  out  1  delayed isActive.

Function
REQ-005 lineOk SHALL be (yPos[8]==0 && yPos<192); fetchWin SHALL be lineOk && (xPos>=-8 && xPos<=247), signed compare; phase SHALL be xPos[2:0].
REQ-006 The fetch FSM SHALL have states IDLE, NAME_REQ, NAME_WAIT, PAT_REQ, PAT_WAIT, COL_REQ, COL_WAIT, advancing one state per clock in that order.
REQ-007 IDLE->NAME_REQ SHALL occur only on an edge where phase==0 && fetchWin; COL_WAIT->IDLE unconditionally; all other states SHALL advance unconditionally.
REQ-008 The fetch column SHALL be tcol = xPos[7:3]+1, 5-bit wrap (xPos=-8 fetches column 0); tcol and trow=yPos[7:3], fine=yPos[2:0] SHALL be latched on the IDLE->NAME_REQ edge.
REQ-009 In NAME_REQ: vramAddr=NAME_BASE+{trow,tcol}, vramRd=1.
REQ-010 In NAME_WAIT: vramData SHALL be latched as name.
REQ-011 In PAT_REQ: vramAddr=PATTERN_BASE+{name,fine}, vramRd=1.
REQ-012 In PAT_WAIT: vramData SHALL be latched into patNext.
REQ-013 In COL_REQ: vramAddr=COLOR_BASE+name[7:3], vramRd=1.
REQ-014 In COL_WAIT: vramData SHALL be latched into colNext (fg=[7:4], bg=[3:0]).
REQ-015 In all other states vramRd SHALL be 0 and vramAddr SHALL hold its last value.
REQ-016 Address arithmetic SHALL be 14-bit modulo 2^14.
REQ-017 On every edge where phase==0, the pixel shifter SHALL load patNext and the color register SHALL load colNext; on other edges the shifter SHALL shift left by one.
REQ-018 Output SHALL be registered, latency 1: on the edge sampling xPos=X, pixel SHALL become fg if the current pattern bit 7 is 1 else bg, when isActive; backdrop otherwise.
- At phase==0 the current pattern bit 7 SHALL be patNext[7]; otherwise it SHALL be the shifter bit 7.
REQ-019 hSyncOut, vSyncOut and activeOut SHALL be hSync, vSync and isActive delayed by exactly one clock, aligned with pixel.
REQ-020 If xPos jumps (hShift change) while the FSM is busy, the sequence SHALL complete unaltered; a new sequence SHALL start only from IDLE.
REQ-021 No fetch SHALL start for xPos>=248, for lines with lineOk=0, or at xPos=-16 (stale data is never displayed, since activeOut=0 there).
REQ-022 If isActive and the fetch window disagree (border), isActive SHALL govern the pixel source.

Reset
REQ-023 While reset=1, the FSM SHALL be IDLE, all outputs SHALL be 0 (pixel=0, vramAddr=0, vramRd=0, hSyncOut=0, vSyncOut=0, activeOut=0), and name, patNext, colNext, the shifter and the color register SHALL be 0.
REQ-024 Reset SHALL act asynchronously; on release, operation SHALL resume at the next phase==0 edge inside fetchWin.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence with no further vramRd pulses.

Verification
REQ-026 Line yPos=0 with xPos stepping -8..7 and VRAM name[0x1800]=0x05, pattern[0x0028]=0xA5, color[0x2000]=0xF1 -> vramRd pulses at 0x1800, 0x0028, 0x2000; pixels for X=0..7 = F,1,F,1,1,F,1,F, each one clock after its xPos.
REQ-027 yPos=13, xPos=-8 -> first address 0x1800+32*1+0=0x1820; pattern address PATTERN_BASE+name*8+5.
REQ-028 xPos=248..255 -> no vramRd; xPos=256 (isActive=0) with backdrop=4 -> pixel=4, activeOut=0.
REQ-029 yPos=192 full line -> zero vramRd pulses; pixel=backdrop throughout.
REQ-030 reset pulsed during PAT_REQ -> outputs 0 immediately, no COL_REQ read; correct pixels from the next tile group onward.
REQ-031 hSync/vSync toggle pattern -> hSyncOut/vSyncOut reproduce it delayed exactly 1 clock.
